ahb_sram_slave: RTL and testbench

AHB-Lite responder fronting the on-chip data RAM (0xB0 region). It accepts transfers from the core's AHB master path, decodes size and byte lanes, and inserts a configurable number of wait states. Illegal transfers get the two-cycle ERROR response. Read data always returns as a full 32-bit word; sign/zero extension stays in the master.

---
 rtl/ahb_pkg.sv | 41 ++++
 rtl/ahb_sram_slave_if.sv | 27 ++
 rtl/ahb_sram_array.sv | 44 ++++
 rtl/ahb_sram_slave.sv | 162 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes, slave FSM encoding and byte-strobe helper.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_t;

   // Little-endian byte lanes touched by a transfer of the given size/offset.
   // Unsupported sizes produce no strobes.
   function automatic logic [3:0] byte_strobes(input logic [2:0] size, input logic [1:0] offset);
      logic [3:0] strb;
      strb = 4'b0000;
      case (size)
         HSIZE_BYTE: strb = 4'b0001 << offset;
         HSIZE_HALF: strb = offset[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: strb = 4'b1111;
         default:    strb = 4'b0000;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the master path and the SRAM responder.
interface ahb_sram_slave_if;
   import ahb_pkg::*;

   logic        hsel;
   logic [31:0] haddr;
   htrans_t     htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      output hreadyout, hresp, hrdata
   );

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/ahb_sram_array.sv
// Byte-enabled 32-bit RAM: one write port, one registered read port, one clock.
// Each byte lane is its own array so the tools map it onto block RAM byte enables.
module ahb_sram_array #(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_strb,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] q_reg;

         // Lane write under its strobe; contents are never reset.
         always_ff @(posedge clk) begin
            if (wr_en && wr_strb[gi]) begin
               mem[wr_addr] <= wr_data[gi*8 +: 8];
            end
         end

         // Registered read; holds its value when no read is requested.
         always_ff @(posedge clk) begin
            if (srst) begin
               q_reg <= '0;
            end else if (rd_en) begin
               q_reg <= mem[rd_addr];
            end
         end
      end
   endgenerate

   assign rd_data = {g_lane[3].q_reg, g_lane[2].q_reg, g_lane[1].q_reg, g_lane[0].q_reg};

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder for the on-chip data RAM: decodes size/lanes, inserts
// WAIT_STATES data-phase waits, and answers illegal transfers with a
// two-cycle ERROR. Reads return the full 32-bit word.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic             hclk,
   input  logic             hreset,
   ahb_sram_slave_if.slave  bus
);

   localparam int         IW        = $clog2(DEPTH_WORDS);
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

   slave_state_t  state_reg;
   logic [2:0]    cnt_reg;
   logic [IW-1:0] idx_reg;
   logic [1:0]    off_reg;
   logic [2:0]    size_reg;
   logic          write_reg;
   logic          hreadyout_reg;
   logic          hresp_reg;

   logic [23:0]   addr_lo;
   logic [IW-1:0] addr_idx;
   logic          out_of_range;
   logic          misaligned;
   logic          bad_size;
   logic          illegal;
   logic          data_done;
   logic          can_accept;
   logic          accept;

   logic          wr_en;
   logic [3:0]    wr_strb;
   logic          rd_en;
   logic [IW-1:0] rd_addr;
   logic [31:0]   ram_q;

   logic          fwd_hit_reg;
   logic [3:0]    fwd_strb_reg;
   logic [31:0]   fwd_data_reg;

   logic          unused_bits;

   // Address-phase decode
   assign addr_lo      = bus.haddr[23:0];
   assign addr_idx     = addr_lo[IW+1:2];
   assign out_of_range = (addr_lo >> (IW + 2)) != 24'd0;
   assign bad_size     = bus.hsize > HSIZE_WORD;
   assign misaligned   = ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) ||
                         ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));
   assign illegal      = bad_size || misaligned || out_of_range;

   // A new address phase can only be taken when this slave is not stalling
   assign data_done  = (state_reg == ST_DATA) && (cnt_reg == 3'd0);
   assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_ERR2) || data_done;
   assign accept     = bus.hsel && bus.hready && bus.htrans[1] && can_accept;

   // Write commits at the edge that ends the completing data cycle; reset aborts it
   assign wr_en   = data_done && write_reg && !hreset;
   assign wr_strb = byte_strobes(size_reg, off_reg);

   // With no waits the RAM must be read at accept; otherwise on the last wait cycle
   generate
      if (WAIT_STATES == 0) begin : g_rd_at_accept
         assign rd_en   = accept && !illegal && !bus.hwrite && !hreset;
         assign rd_addr = addr_idx;
      end else begin : g_rd_at_last_wait
         assign rd_en   = (state_reg == ST_DATA) && (cnt_reg == 3'd1) && !write_reg && !hreset;
         assign rd_addr = idx_reg;
      end
   endgenerate

   assign unused_bits = ^{bus.hprot, bus.haddr[31:24], bus.htrans[0]};

   // Transfer FSM with registered hreadyout/hresp
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         off_reg       <= '0;
         size_reg      <= '0;
         write_reg     <= 1'b0;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= HRESP_OKAY;
      end else if ((state_reg == ST_DATA) && (cnt_reg != 3'd0)) begin
         cnt_reg       <= cnt_reg - 3'd1;
         hreadyout_reg <= (cnt_reg == 3'd1);
      end else if (state_reg == ST_ERR1) begin
         state_reg     <= ST_ERR2;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= HRESP_ERROR;
      end else if (accept) begin
         idx_reg   <= addr_idx;
         off_reg   <= bus.haddr[1:0];
         size_reg  <= bus.hsize;
         write_reg <= bus.hwrite;
         if (illegal) begin
            state_reg     <= ST_ERR1;
            cnt_reg       <= '0;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= HRESP_ERROR;
         end else begin
            state_reg     <= ST_DATA;
            cnt_reg       <= WAIT_INIT;
            hreadyout_reg <= (WAIT_INIT == 3'd0);
            hresp_reg     <= HRESP_OKAY;
         end
      end else begin
         state_reg     <= ST_IDLE;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= HRESP_OKAY;
      end
   end

   ahb_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (hclk),
      .srst    (hreset),
      .wr_en   (wr_en),
      .wr_addr (idx_reg),
      .wr_strb (wr_strb),
      .wr_data (bus.hwdata),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   // Capture a same-cycle write to the word being read so its lanes override stale RAM data
   always_ff @(posedge hclk) begin
      if (hreset) begin
         fwd_hit_reg  <= 1'b0;
         fwd_strb_reg <= '0;
         fwd_data_reg <= '0;
      end else if (rd_en) begin
         fwd_hit_reg  <= wr_en && (rd_addr == idx_reg);
         fwd_strb_reg <= wr_strb;
         fwd_data_reg <= bus.hwdata;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rd_lane
         logic [7:0] byte_out;
         assign byte_out = (fwd_hit_reg && fwd_strb_reg[gi]) ? fwd_data_reg[gi*8 +: 8]
                                                              : ram_q[gi*8 +: 8];
      end
   endgenerate

   assign bus.hrdata    = {g_rd_lane[3].byte_out, g_rd_lane[2].byte_out,
                           g_rd_lane[1].byte_out, g_rd_lane[0].byte_out};
   assign bus.hreadyout = hreadyout_reg;
   assign bus.hresp     = hresp_reg;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a cycle table for a zero-wait instance plus hand-written
// sequences for a three-wait instance and reset during a write.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   localparam logic [31:0] BASE = 32'hB000_0000;

   logic hclk = 1'b0;
   logic hreset;

   always #5 hclk = ~hclk;

   ahb_sram_slave_if bus0();
   ahb_sram_slave_if bus3();

   assign bus0.hready = bus0.hreadyout;
   assign bus3.hready = bus3.hreadyout;

   ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus0)
   );

   ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus3)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // One row = one clock cycle: address phase driven this cycle, hwdata for the
   // previous address phase, and the outputs expected during this cycle.
   typedef struct {
      logic        sel;
      htrans_t     trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_ready;
      logic        exp_resp;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic sel, input htrans_t trans, input logic wr,
                               input logic [2:0] size, input logic [31:0] off,
                               input logic [31:0] wdata, input logic er, input logic eresp,
                               input logic chk, input logic [31:0] erd);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = BASE + off;
      v.wdata = wdata; v.exp_ready = er; v.exp_resp = eresp; v.chk_rdata = chk;
      v.exp_rdata = erd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive0(input vec_t v);
      bus0.hsel   = v.sel;
      bus0.htrans = v.trans;
      bus0.hwrite = v.wr;
      bus0.hsize  = v.size;
      bus0.haddr  = v.addr;
      bus0.hwdata = v.wdata;
      bus0.hprot  = 4'b0011;
   endtask

   task automatic idle3();
      bus3.hsel   = 1'b0;
      bus3.htrans = HTRANS_IDLE;
      bus3.hwrite = 1'b0;
      bus3.hsize  = 3'd0;
      bus3.haddr  = 32'd0;
   endtask

   task automatic addr3(input logic wr, input logic [2:0] size, input logic [31:0] off);
      bus3.hsel   = 1'b1;
      bus3.htrans = HTRANS_NONSEQ;
      bus3.hwrite = wr;
      bus3.hsize  = size;
      bus3.haddr  = BASE + off;
      bus3.hprot  = 4'b0011;
   endtask

   // Data phase of an OKAY transfer on the 3-wait slave: 3 stalled cycles then ready
   task automatic data3(input logic [31:0] wdata, input logic chk_rd,
                        input logic [31:0] exp_rd, input string tag);
      tick();
      idle3();
      bus3.hwdata = wdata;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s ready c%0d", tag, k), 32'(bus3.hreadyout), 32'(k == 3));
         check($sformatf("%s resp c%0d", tag, k), 32'(bus3.hresp), 32'(HRESP_OKAY));
         if (k < 3) tick();
      end
      if (chk_rd) check({tag, " rdata"}, bus3.hrdata, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 'h10,   32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h10,   32'hDEADBEEF, 1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'hDEADBEEF));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 'h13,   32'h0,        1, 0, 1, 32'hDEADBEEF));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 'h10,   32'h5A000000, 1, 0, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h10,   32'h00001234, 1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'h5AAD1234));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 'h20,   32'h0,        1, 0, 1, 32'h5AAD1234));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 'h22,   32'hCAFEF00D, 1, 0, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h20,   32'hBEEF9999, 1, 0, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_BUSY,   0, HSIZE_WORD, 'h10,   32'h0,        1, 0, 1, 32'hBEEFF00D));
      vecs.push_back(mk(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h10,   32'h0,        1, 0, 1, 32'hBEEFF00D));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h20,   32'h0,        1, 0, 1, 32'hBEEFF00D));
      vecs.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 'h10,   32'h0,        1, 0, 1, 32'hBEEFF00D));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'h5AAD1234));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'h5AAD1234));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h12,   32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        0, 1, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 1, 1, 32'h5AAD1234));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 'h12,   32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'hFFFFFFFF, 0, 1, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h10,   32'hFFFFFFFF, 1, 1, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'h5AAD1234));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h1000, 32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        0, 1, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h20,   32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'hBEEFF00D));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 'h1010, 32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        0, 1, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 'h10,   32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'h5AAD1234));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_HALF, 'h11,   32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        0, 1, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd3,       'h10,   32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        0, 1, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 'h13,   32'h0,        1, 0, 0, 32'h0));
      vecs.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 'h0,    32'h0,        1, 0, 1, 32'h5AAD1234));

      // Reset state of both instances
      hreset = 1'b1;
      drive0(mk(0, HTRANS_IDLE, 0, HSIZE_WORD, 'h0, 32'h0, 1, 0, 0, 32'h0));
      idle3();
      bus3.hwdata = 32'h0;
      bus3.hprot  = 4'b0;
      tick();
      tick();
      check("reset ws0 ready", 32'(bus0.hreadyout), 32'd1);
      check("reset ws0 resp",  32'(bus0.hresp),     32'd0);
      check("reset ws0 rdata", bus0.hrdata,         32'h0);
      check("reset ws3 ready", 32'(bus3.hreadyout), 32'd1);
      check("reset ws3 resp",  32'(bus3.hresp),     32'd0);
      check("reset ws3 rdata", bus3.hrdata,         32'h0);
      hreset = 1'b0;

      // Zero-wait instance, one table row per cycle
      for (int i = 0; i < vecs.size(); i++) begin
         tick();
         check($sformatf("vec%0d ready", i), 32'(bus0.hreadyout), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d resp", i),  32'(bus0.hresp),     32'(vecs[i].exp_resp));
         if (vecs[i].chk_rdata) begin
            check($sformatf("vec%0d rdata", i), bus0.hrdata, vecs[i].exp_rdata);
         end
         drive0(vecs[i]);
      end

      // Three-wait instance: write, then read back with waits
      tick();
      addr3(1'b1, HSIZE_WORD, 'h40);
      data3(32'h0BADF00D, 1'b0, 32'h0, "ws3 write");
      addr3(1'b0, HSIZE_WORD, 'h40);
      data3(32'h0, 1'b1, 32'h0BADF00D, "ws3 read");

      // BUSY then IDLE while selected: single-cycle OKAY, no access
      bus3.hsel   = 1'b1;
      bus3.htrans = HTRANS_BUSY;
      bus3.haddr  = BASE + 32'h44;
      tick();
      check("ws3 busy ready", 32'(bus3.hreadyout), 32'd1);
      check("ws3 busy resp",  32'(bus3.hresp),     32'd0);
      check("ws3 busy rdata", bus3.hrdata,         32'h0BADF00D);
      bus3.htrans = HTRANS_IDLE;
      tick();
      check("ws3 idle ready", 32'(bus3.hreadyout), 32'd1);
      check("ws3 idle resp",  32'(bus3.hresp),     32'd0);

      // ERROR is two cycles even with waits configured
      addr3(1'b0, HSIZE_WORD, 'h42);
      tick();
      idle3();
      check("ws3 err c0 ready", 32'(bus3.hreadyout), 32'd0);
      check("ws3 err c0 resp",  32'(bus3.hresp),     32'd1);
      tick();
      check("ws3 err c1 ready", 32'(bus3.hreadyout), 32'd1);
      check("ws3 err c1 resp",  32'(bus3.hresp),     32'd1);
      tick();
      check("ws3 err after ready", 32'(bus3.hreadyout), 32'd1);
      check("ws3 err after resp",  32'(bus3.hresp),     32'd0);

      // Reset during a wait cycle of a write aborts it
      addr3(1'b1, HSIZE_WORD, 'h40);
      tick();
      idle3();
      bus3.hwdata = 32'hFFFF0000;
      check("ws3 rstwr wait ready", 32'(bus3.hreadyout), 32'd0);
      hreset = 1'b1;
      tick();
      check("ws3 rstwr ready", 32'(bus3.hreadyout), 32'd1);
      check("ws3 rstwr resp",  32'(bus3.hresp),     32'd0);
      check("ws3 rstwr rdata", bus3.hrdata,         32'h0);
      check("ws0 rst rdata",   bus0.hrdata,         32'h0);
      hreset = 1'b0;
      addr3(1'b0, HSIZE_WORD, 'h40);
      data3(32'h0, 1'b1, 32'h0BADF00D, "ws3 read after reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
